// File: rtl/trap_report_arbiter.sv
// trap_report_arbiter
//   Shares one simulation Monitor port between NUM_REQ harts. Each hart offers a
//   trap report (code, PC). Reports are round-robin arbitrated and handed to the
//   Monitor one at a time. The block also keeps the global cycle and instruction
//   counters that the Monitor samples.
//
// Handshake: a report from hart i moves in any cycle where req_valid[i] and
//   req_ready[i] are both 1. req_ready is combinational and is asserted in the
//   same cycle as the grant. A hart whose valid is not granted must keep it
//   asserted until ready. Harts that have already reported always see ready=1.
//   Their repeat reports are drained and discarded.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   req_valid/ready  per-hart report handshake
//   req_code/pc      per-hart trap code (32b) and PC (PC_W), hart i at slice i
//   instr_commit     per-hart commit count this cycle (COMMIT_W each)
//   mon_is_trap      one-cycle report strobe
//   mon_trap_code/pc/req_id  last report (held until the next report)
//   mon_cycle_cnt    cycles since reset
//   mon_instr_cnt    total instructions committed by all harts
//   done             sticky, set when reporting is finished
//   dbg_state        current FSM state (0 IDLE, 1 REPORT, 2 DONE)
module trap_report_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int PC_W          = 64,
  parameter int CNT_W         = 32,
  parameter int COMMIT_W      = 3,
  parameter int STOP_ON_FIRST = 1,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*32-1:0]        req_code,
  input  logic [NUM_REQ*PC_W-1:0]      req_pc,
  input  logic [NUM_REQ*COMMIT_W-1:0]  instr_commit,
  output logic                         mon_is_trap,
  output logic [31:0]                  mon_trap_code,
  output logic [PC_W-1:0]              mon_trap_pc,
  output logic [ID_W-1:0]              mon_req_id,
  output logic [CNT_W-1:0]             mon_cycle_cnt,
  output logic [CNT_W-1:0]             mon_instr_cnt,
  output logic                         done,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REPORT = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0]   r_trapped;
  logic [31:0]          r_code;
  logic [PC_W-1:0]      r_pc;
  logic [ID_W-1:0]      r_id;
  logic [CNT_W-1:0]     r_cycle;
  logic [CNT_W-1:0]     r_instr;

  logic [NUM_REQ-1:0]   w_eligible;
  logic                 w_grant_vld;
  logic [ID_W-1:0]      w_grant_id;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic [CNT_W-1:0]     w_commit_sum;
  logic                 w_take;

  // (base + k) mod NUM_REQ, used for both the round-robin search and pointer advance
  function automatic logic [ID_W-1:0] f_rr_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return ID_W'(s);
  endfunction

  // Harts that have already reported never compete again.
  assign w_eligible = req_valid & ~r_trapped;

  // The first eligible hart wins, searching upward from r_rr_ptr with wrap-around.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_grant_vld && w_eligible[f_rr_idx(r_rr_ptr, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = f_rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_grant_oh = w_grant_vld ? (NUM_REQ'(1) << w_grant_id) : '0;

  always_comb begin
    w_commit_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_commit_sum = w_commit_sum + CNT_W'(instr_commit[i*COMMIT_W +: COMMIT_W]);
    end
  end

  // Next-state and handshake logic
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = '0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = r_trapped | w_grant_oh;
        if (w_grant_vld) w_next_state = S_REPORT;
      end
      S_REPORT: begin
        w_req_ready = r_trapped;
        // r_trapped already includes the hart that is being reported now
        if ((STOP_ON_FIRST != 0) || (&r_trapped)) w_next_state = S_DONE;
        else                                      w_next_state = S_IDLE;
      end
      S_DONE: begin
        w_req_ready = '1;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_take = (r_state == S_IDLE) && w_grant_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_trapped <= '0;
      r_code    <= '0;
      r_pc      <= '0;
      r_id      <= '0;
      r_cycle   <= '0;
      r_instr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cycle <= r_cycle + CNT_W'(1);
      r_instr <= r_instr + w_commit_sum;
      if (w_take) begin
        r_code    <= req_code[32*w_grant_id +: 32];
        r_pc      <= req_pc[PC_W*w_grant_id +: PC_W];
        r_id      <= w_grant_id;
        r_trapped <= r_trapped | w_grant_oh;
        r_rr_ptr  <= f_rr_idx(w_grant_id, 1);
      end
    end
  end

  // The strobe comes straight from the state register, so an asynchronous reset removes it at once.
  assign mon_is_trap   = (r_state == S_REPORT);
  assign done          = (r_state == S_DONE);
  assign req_ready     = w_req_ready;
  assign mon_trap_code = r_code;
  assign mon_trap_pc   = r_pc;
  assign mon_req_id    = r_id;
  assign mon_cycle_cnt = r_cycle;
  assign mon_instr_cnt = r_instr;
  assign dbg_state     = r_state;

endmodule
